// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
// mem_initiator : single-outstanding LW/SW/LB/SB initiator onto a word memory
//                 with big-endian byte lanes and read-modify-write byte stores.
// Revision      : 1.0  initial release
// ============================================================================
module mem_initiator #(
  parameter bit LB_SIGN_EXT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic [1:0]  Req_Op,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_Data,
  output logic        Resp_Valid,
  output logic [31:0] Resp_Data,
  output logic        Resp_Err,
  output logic        Mem_WrEn,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WrData,
  input  logic [31:0] Mem_RdData
);

  localparam logic [1:0] OP_LW = 2'b00;
  localparam logic [1:0] OP_SW = 2'b01;
  localparam logic [1:0] OP_LB = 2'b10;
  localparam logic [1:0] OP_SB = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [1:0]  off_q;
  logic [7:0]  byte_q;
  logic        misaligned;

  // Offset 0 is the most significant byte of the word.
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] off);
    case (off)
      2'd0:    get_byte = w[31:24];
      2'd1:    get_byte = w[23:16];
      2'd2:    get_byte = w[15:8];
      default: get_byte = w[7:0];
    endcase
  endfunction

  function automatic logic [31:0] merge_byte(input logic [31:0] w, input logic [1:0] off,
                                             input logic [7:0] b);
    case (off)
      2'd0:    merge_byte = {b, w[23:0]};
      2'd1:    merge_byte = {w[31:24], b, w[15:0]};
      2'd2:    merge_byte = {w[31:16], b, w[7:0]};
      default: merge_byte = {w[31:8], b};
    endcase
  endfunction

  function automatic logic [31:0] extend_byte(input logic [7:0] b);
    logic fill;
    fill = LB_SIGN_EXT & b[7];
    extend_byte = {{24{fill}}, b};
  endfunction

  // Only word accesses can be misaligned; byte accesses never are.
  assign misaligned = ~Req_Op[1] & (|Req_Addr[1:0]);
  assign Req_Ready  = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= 2'b00;
      off_q      <= 2'b00;
      byte_q     <= 8'h00;
      Resp_Valid <= 1'b0;
      Resp_Data  <= 32'h0;
      Resp_Err   <= 1'b0;
      Mem_WrEn   <= 1'b0;
      Mem_Addr   <= 32'h0;
      Mem_WrData <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (Req_Valid) begin
            op_q   <= Req_Op;
            off_q  <= Req_Addr[1:0];
            byte_q <= Req_Data[7:0];
            if (misaligned) begin
              state      <= RESP;
              Resp_Valid <= 1'b1;
              Resp_Err   <= 1'b1;
              Resp_Data  <= 32'h0;
            end else begin
              Mem_Addr <= {Req_Addr[31:2], 2'b00};
              case (Req_Op)
                OP_SW: begin
                  state      <= WR;
                  Mem_WrEn   <= 1'b1;
                  Mem_WrData <= Req_Data;
                end
                OP_SB:   state <= RMW_RD;
                default: state <= RD;
              endcase
            end
          end
        end
        RD: begin
          Resp_Data  <= (op_q == OP_LB) ? extend_byte(get_byte(Mem_RdData, off_q)) : Mem_RdData;
          Resp_Valid <= 1'b1;
          state      <= RESP;
        end
        WR: begin
          Mem_WrEn   <= 1'b0;
          Resp_Data  <= 32'h0;
          Resp_Valid <= 1'b1;
          state      <= RESP;
        end
        RMW_RD: begin
          Mem_WrData <= merge_byte(Mem_RdData, off_q, byte_q);
          Mem_WrEn   <= 1'b1;
          state      <= RMW_WR;
        end
        RMW_WR: begin
          Mem_WrEn   <= 1'b0;
          Resp_Data  <= 32'h0;
          Resp_Valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          Resp_Valid <= 1'b0;
          Resp_Err   <= 1'b0;
          Resp_Data  <= 32'h0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// Testbench for mem_initiator: word memory model, response scoreboard,
// sign- and zero-extending instances driven in lockstep.
module tb_mem_initiator;

  localparam logic [1:0] OP_LW = 2'b00;
  localparam logic [1:0] OP_SW = 2'b01;
  localparam logic [1:0] OP_LB = 2'b10;
  localparam logic [1:0] OP_SB = 2'b11;

  logic        clk;
  logic        rst;
  logic        Req_Valid;
  logic [1:0]  Req_Op;
  logic [31:0] Req_Addr;
  logic [31:0] Req_Data;

  logic        Req_Ready,  Req_Ready_z;
  logic        Resp_Valid, Resp_Valid_z;
  logic [31:0] Resp_Data,  Resp_Data_z;
  logic        Resp_Err,   Resp_Err_z;
  logic        Mem_WrEn,   Mem_WrEn_z;
  logic [31:0] Mem_Addr,   Mem_Addr_z;
  logic [31:0] Mem_WrData, Mem_WrData_z;
  logic [31:0] Mem_RdData, Mem_RdData_z;

  logic [31:0] mem [0:63];

  typedef struct {
    logic [31:0] data;
    logic [31:0] data_z;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int acc_ncyc = 0;
  int acc_cnt = 0;
  int acc_gap = 0;
  int resp_cnt = 0;
  int wr_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;

  mem_initiator dut (
    .clk(clk), .rst(rst),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Op(Req_Op),
    .Req_Addr(Req_Addr), .Req_Data(Req_Data),
    .Resp_Valid(Resp_Valid), .Resp_Data(Resp_Data), .Resp_Err(Resp_Err),
    .Mem_WrEn(Mem_WrEn), .Mem_Addr(Mem_Addr), .Mem_WrData(Mem_WrData),
    .Mem_RdData(Mem_RdData)
  );

  mem_initiator #(.LB_SIGN_EXT(1'b0)) dut_z (
    .clk(clk), .rst(rst),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready_z), .Req_Op(Req_Op),
    .Req_Addr(Req_Addr), .Req_Data(Req_Data),
    .Resp_Valid(Resp_Valid_z), .Resp_Data(Resp_Data_z), .Resp_Err(Resp_Err_z),
    .Mem_WrEn(Mem_WrEn_z), .Mem_Addr(Mem_Addr_z), .Mem_WrData(Mem_WrData_z),
    .Mem_RdData(Mem_RdData_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign Mem_RdData   = mem[Mem_Addr[7:2]];
  assign Mem_RdData_z = mem[Mem_Addr_z[7:2]];

  always @(posedge clk) begin
    if (Mem_WrEn) mem[Mem_Addr[7:2]] <= Mem_WrData;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (!rst) begin
      if (Resp_Valid) begin
        resp_cnt++;
        if (sb.size() == 0) begin
          chk("spurious_resp", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("resp_data",   Resp_Data, e.data);
          chk("resp_err",    32'(Resp_Err), 32'(e.err));
          chk("latency",     32'(ncyc - acc_ncyc), 32'(e.lat));
          chk("resp_valid_z", 32'(Resp_Valid_z), 32'd1);
          chk("resp_data_z", Resp_Data_z, e.data_z);
          chk("resp_err_z",  32'(Resp_Err_z), 32'(e.err));
        end
      end
      if (Mem_WrEn) begin
        wr_cnt++;
        last_wr_addr = Mem_Addr;
        chk("wr_addr_z",  Mem_Addr_z, Mem_Addr);
        chk("wr_en_z",    32'(Mem_WrEn_z), 32'd1);
        chk("wr_data_z",  Mem_WrData_z, Mem_WrData);
      end
      if (Req_Valid && Req_Ready) begin
        acc_gap  = ncyc - acc_ncyc;
        acc_ncyc = ncyc;
        acc_cnt++;
      end
    end
  end

  task automatic push_exp(input logic [31:0] d, input logic [31:0] dz, input logic err, input int lat);
    exp_t e;
    e.data = d; e.data_z = dz; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] d, input logic [31:0] dz, input logic err, input int lat);
    for (int i = 0; i < 20 && !Req_Ready; i++) begin
      @(posedge clk); #1;
    end
    if (!Req_Ready) chk("ready_timeout", 32'(Req_Ready), 32'd1);
    Req_Valid = 1'b1; Req_Op = op; Req_Addr = addr; Req_Data = data;
    push_exp(d, dz, err, lat);
    @(posedge clk); #1;
    Req_Valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] d, input logic [31:0] dz, input logic err, input int lat);
    issue(op, addr, data, d, dz, err, lat);
    drain();
  endtask

  initial begin
    int wb;
    int ab;
    int rb;
    rst = 1'b1; Req_Valid = 1'b0; Req_Op = 2'b00; Req_Addr = 32'h0; Req_Data = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",      32'(Req_Ready), 32'd1);
    chk("rst_ready_z",    32'(Req_Ready_z), 32'd1);
    chk("rst_resp_valid", 32'(Resp_Valid), 32'd0);
    chk("rst_resp_err",   32'(Resp_Err), 32'd0);
    chk("rst_wren",       32'(Mem_WrEn), 32'd0);
    chk("rst_resp_data",  Resp_Data, 32'h0);
    chk("rst_mem_addr",   Mem_Addr, 32'h0);
    chk("rst_wrdata",     Mem_WrData, 32'h0);
    rst = 1'b0;

    // SW in the first cycle after reset release, then LW back.
    wb = wr_cnt;
    send(OP_SW, 32'h4, 32'h1, 32'h0, 32'h0, 1'b0, 2);
    chk("sw_write_count", 32'(wr_cnt - wb), 32'd1);
    chk("sw_write_addr",  last_wr_addr, 32'h4);
    chk("sw_mem",         mem[1], 32'h1);
    send(OP_LW, 32'h4, 32'h0, 32'h1, 32'h1, 1'b0, 2);

    // SB merge into byte 1 of 0x11223344.
    mem[2] <= 32'h11223344;
    @(posedge clk); #1;
    wb = wr_cnt;
    send(OP_SB, 32'h9, 32'hAA, 32'h0, 32'h0, 1'b0, 3);
    chk("sb_write_count", 32'(wr_cnt - wb), 32'd1);
    chk("sb_write_addr",  last_wr_addr, 32'h8);
    chk("sb_mem",         mem[2], 32'h11AA3344);

    // LB every lane, negative and positive bytes.
    send(OP_LB, 32'h9, 32'h0, 32'hFFFFFFAA, 32'h000000AA, 1'b0, 2);
    send(OP_LB, 32'h8, 32'h0, 32'h00000011, 32'h00000011, 1'b0, 2);
    send(OP_LB, 32'hA, 32'h0, 32'h00000033, 32'h00000033, 1'b0, 2);
    send(OP_LB, 32'hB, 32'h0, 32'h00000044, 32'h00000044, 1'b0, 2);
    send(OP_LW, 32'h8, 32'h0, 32'h11AA3344, 32'h11AA3344, 1'b0, 2);

    // SB at lanes 0 and 3; only Data[7:0] matters.
    send(OP_SB, 32'h8, 32'h5A, 32'h0, 32'h0, 1'b0, 3);
    send(OP_SB, 32'hB, 32'hFFFFFF80, 32'h0, 32'h0, 1'b0, 3);
    chk("sb_lanes_mem", mem[2], 32'h5AAA3380);
    send(OP_LB, 32'hB, 32'h0, 32'hFFFFFF80, 32'h00000080, 1'b0, 2);

    send(OP_SW, 32'h10, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 2);
    send(OP_LW, 32'h10, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2);

    // Misaligned word accesses: error, 1-cycle latency, no write.
    wb = wr_cnt;
    send(OP_LW, 32'h6, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    send(OP_SW, 32'hE, 32'h12345678, 32'h0, 32'h0, 1'b1, 1);
    send(OP_LW, 32'h7, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    chk("misaligned_no_write", 32'(wr_cnt - wb), 32'd0);
    chk("misaligned_mem", mem[3], 32'h0);
    send(OP_LB, 32'h11, 32'h0, 32'hFFFFFFAD, 32'h000000AD, 1'b0, 2);

    // Req_Valid held high: one response per accept, re-accept after RESP.
    ab = acc_cnt; rb = resp_cnt;
    push_exp(32'h1, 32'h1, 1'b0, 2);
    push_exp(32'h1, 32'h1, 1'b0, 2);
    Req_Valid = 1'b1; Req_Op = OP_LW; Req_Addr = 32'h4; Req_Data = 32'h0;
    for (int i = 0; i < 20 && (acc_cnt - ab) < 2; i++) begin
      @(posedge clk); #1;
    end
    Req_Valid = 1'b0;
    drain();
    chk("busy_accepts",   32'(acc_cnt - ab), 32'd2);
    chk("busy_responses", 32'(resp_cnt - rb), 32'd2);
    chk("busy_accept_gap", 32'(acc_gap), 32'd3);

    // Reset during RMW_WR: write enable drops at once, word untouched.
    mem[5] <= 32'hCAFEF00D;
    @(posedge clk); #1;
    wb = wr_cnt;
    issue(OP_SB, 32'h15, 32'h00, 32'h0, 32'h0, 1'b0, 3);
    @(posedge clk); #1;
    chk("rmw_wren_before_rst", 32'(Mem_WrEn), 32'd1);
    rst = 1'b1;
    #1;
    chk("rmw_rst_wren",  32'(Mem_WrEn), 32'd0);
    chk("rmw_rst_ready", 32'(Req_Ready), 32'd1);
    chk("rmw_rst_resp",  32'(Resp_Valid), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rmw_rst_mem",   mem[5], 32'hCAFEF00D);
    chk("rmw_rst_no_write", 32'(wr_cnt - wb), 32'd0);
    send(OP_LW, 32'h14, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 2);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; the polarity and synchronicity are fixed.
REQ-002 Parameter: LB_SIGN_EXT, default 1, meaning LB result is sign-extended (1) or zero-extended (0).
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 Req_Valid  in  1  pipeline request present.
REQ-006 Req_Ready  out  1  block can accept a request this cycle.
REQ-007 Req_Op  in  2  operation: 00 LW, 01 SW, 10 LB, 11 SB.
REQ-008 Req_Addr  in  32  byte address.
REQ-009 Req_Data  in  32  store data; SB uses bits [7:0].
REQ-010 Resp_Valid  out  1  one-cycle completion pulse.
REQ-011 Resp_Data  out  32  load result, or 0 for stores and errors.
REQ-012 Resp_Err  out  1  misaligned-access flag, valid with Resp_Valid.
REQ-013 Mem_WrEn  out  1  data-memory write enable.
REQ-014 Mem_Addr  out  32  data-memory word address; bits [1:0] are always 00.
REQ-015 Mem_WrData  out  32  data-memory write data.
REQ-016 Mem_RdData  in  32  data-memory read data, combinational from Mem_Addr.

Function
REQ-017 States SHALL be IDLE, RD, WR, RMW_RD, RMW_WR and RESP.
REQ-018 Req_Ready SHALL be 1 only in IDLE; a request is accepted on a rising edge when Req_Valid=1 in IDLE, and Op, Addr and Data are latched at that edge.
REQ-019 From IDLE on accept, the next state SHALL be:
- LW or LB: RD.
- SW: WR.
- SB: RMW_RD.
- LW or SW with Addr[1:0]≠00: RESP with error.
REQ-020 In RD the block SHALL drive Mem_Addr={Addr[31:2],2'b00} with Mem_WrEn=0, capture Mem_RdData at the end of the cycle, then go to RESP.
REQ-021 In WR the block SHALL drive Mem_WrEn=1, Mem_Addr set to the word address, and Mem_WrData=Data for exactly one cycle, then go to RESP.
REQ-022 For SB:
- RMW_RD SHALL read the word at the word address and capture it.
- RMW_WR SHALL write that word with only the addressed byte replaced by Data[7:0], with Mem_WrEn=1 for one cycle.
- The block then goes to RESP.
REQ-023 Byte lanes SHALL be big-endian: offset 0 = bits [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
REQ-024 LB SHALL return the addressed byte in bits [7:0], with bits [31:8] filled by sign extension or zeros per LB_SIGN_EXT.
REQ-025 LB and SB SHALL never flag misalignment.
REQ-026 RESP SHALL assert Resp_Valid=1 for exactly one cycle, then return to IDLE; there is no response backpressure.
REQ-027 RESP contents SHALL be:
- LW: Resp_Data = full captured word.
- LB: Resp_Data = extended byte.
- Stores: Resp_Data = 0.
- Error: Resp_Data = 0 and Resp_Err = 1.
- Otherwise Resp_Err = 0.
REQ-028 Latency from the accept edge to Resp_Valid high SHALL be:
- LW, LB, SW: 2 cycles.
- SB: 3 cycles.
- Misaligned: 1 cycle.
REQ-029 Mem_WrEn SHALL be 1 only in WR and RMW_WR, and a misaligned access SHALL cause no memory access.
REQ-030 A request presented while Req_Ready=0 SHALL be ignored and not queued.
REQ-031 Back-to-back requests SHALL be accepted no earlier than the IDLE cycle following RESP.
REQ-032 All outputs except Req_Ready SHALL be registered.

Reset
REQ-033 Asserting rst SHALL immediately force:
- state = IDLE;
- Req_Ready = 1, Resp_Valid = 0, Resp_Err = 0, Mem_WrEn = 0;
- Resp_Data = 0, Mem_Addr = 0, Mem_WrData = 0;
- latched request and captured word = 0.
REQ-034 Reset during WR or RMW_WR SHALL deassert Mem_WrEn before the next edge, so no write occurs.
REQ-035 Reset during RMW_RD SHALL abandon the SB with memory unmodified.
REQ-036 A request presented in the first cycle after rst deasserts SHALL be accepted normally.

Verification
REQ-037 SW and LW: SW Addr=0x4, Data=0x1 → Mem_WrEn pulse 1 cycle at Mem_Addr=0x4; Resp_Valid 2 cycles after accept. Then LW 0x4 → Resp_Data=0x00000001, Resp_Err=0.
REQ-038 SB merge: memory word 0x8 = 0x11223344; SB Addr=0x9, Data=0xAA → memory = 0x11AA3344; exactly one write, 3-cycle latency.
REQ-039 LB extension: word 0x8 = 0x11AA3344; LB Addr=0x9 → Resp_Data=0xFFFFFFAA with LB_SIGN_EXT=1, and 0x000000AA with LB_SIGN_EXT=0.
REQ-040 Misaligned: LW Addr=0x6 → Resp_Err=1, Resp_Data=0, 1-cycle latency, Mem_WrEn never asserted. Same for SW 0xE.
REQ-041 Reset mid-SB: assert rst in RMW_WR → Mem_WrEn drops immediately, word unchanged, Req_Ready=1.
REQ-042 Busy ignore: Req_Valid held high through a LW → exactly one response; second accept occurs in the IDLE cycle after RESP.
